// File: rtl/tinker_fetch_unit.sv
// tinker_fetch_unit: decoupled instruction prefetch stage.
// Issues word-aligned requests over a valid/ready port, keeps at most one
// request in flight, and buffers {pc, instr} pairs in a DEPTH-entry
// first-word-fall-through FIFO for decode. A redirect flushes the FIFO and
// discards any response that belongs to the old path.
// Optional build macro: TINKER_FETCH_PERF_EN adds saturating perf counters
// (perf_redirects, perf_starve).

module tinker_fetch_unit #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INSTR_W  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'('h2000)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [INSTR_W-1:0]       imem_resp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef TINKER_FETCH_PERF_EN
    ,
    output logic [31:0]              perf_redirects,
    output logic [31:0]              perf_starve
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [1:0] S_REQ  = 2'd0;  // request may be presented
    localparam logic [1:0] S_WAIT = 2'd1;  // accepted request in flight
    localparam logic [1:0] S_DROP = 2'd2;  // in-flight response is stale

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [OCC_W-1:0]    occ;

    logic [ADDR_W-1:0]   mem_pc    [DEPTH];
    logic [INSTR_W-1:0]  mem_instr [DEPTH];

    logic                req_fire;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   redirect_target;

    // A request is only offered when the FIFO has room for its response, so
    // the FIFO can never overflow. Reset masks it so nothing leaks out early.
    assign imem_req_valid  = !reset && (state == S_REQ) && (occ < OCC_W'(DEPTH));
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;

    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Redirect cancels both the push of a same-cycle response and any pop.
    assign push = (state == S_WAIT) && imem_resp_valid && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    assign out_valid = (occ != '0);
    assign occupancy = occ;
    // Storage is not reset, so the head is masked to zero while empty.
    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;

    // Next-state selection for the request/response handshake.
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_REQ: begin
                // A request accepted in the same cycle as a redirect is still
                // in flight and its response must be thrown away.
                if (req_fire) state_next = redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid)     state_next = S_REQ;
                else if (redirect_valid) state_next = S_DROP;
            end
            S_DROP: begin
                if (imem_resp_valid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    // FIFO payload write; entries are only ever read after being written.
    // NOTE: the storage array has no reset -- occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= fetch_pc;
            mem_instr[wr_ptr] <= imem_resp_data;
        end
    end

    // Control state: FSM, fetch PC, FIFO pointers and occupancy.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                occ      <= '0;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end
    end

`ifdef TINKER_FETCH_PERF_EN
    // Saturating counters: redirect cycles and decode-starved cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_redirects <= '0;
            perf_starve    <= '0;
        end else begin
            if (redirect_valid && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 1'b1;
            if (out_ready && !out_valid && (perf_starve != '1))
                perf_starve <= perf_starve + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Self-checking bench for tinker_fetch_unit (default parameters).
// Phase 1: directed cycle table from reset. Phase 2: reset during an
// in-flight request. Phase 3: random traffic against a queue-based model.

module tb_tinker_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  occupancy;
`ifdef TINKER_FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_starve;
`endif

    tinker_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .occupancy       (occupancy)
`ifdef TINKER_FETCH_PERF_EN
        ,
        .perf_redirects  (perf_redirects),
        .perf_starve     (perf_starve)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // One directed cycle: inputs driven this cycle, outputs expected this cycle.
    typedef struct {
        logic        redir;
        logic [63:0] rpc;
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        logic        ordy;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_ov;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic [2:0]  e_occ;
    } vec_t;

    function automatic vec_t mk(input logic redir, input logic [63:0] rpc, input logic rdy,
                                input logic resp, input logic [31:0] data, input logic ordy,
                                input logic e_rv, input logic [63:0] e_addr, input logic e_ov,
                                input logic [63:0] e_pc, input logic [31:0] e_instr,
                                input logic [2:0] e_occ);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.resp = resp; v.data = data; v.ordy = ordy;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_occ = e_occ;
        return v;
    endfunction

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic drive(input logic redir, input logic [63:0] rpc, input logic rdy,
                         input logic resp, input logic [31:0] data, input logic ordy);
        redirect_valid  = redir;
        redirect_pc     = rpc;
        imem_req_ready  = rdy;
        imem_resp_valid = resp;
        imem_resp_data  = data;
        out_ready       = ordy;
    endtask

    // Reference model: expected FIFO contents plus in-flight bookkeeping.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    bit          m_outstanding;
    bit          m_stale;
    // Memory environment: one response owed after a random latency.
    bit          mem_busy;
    int          mem_wait;
    logic [63:0] mem_addr;

    vec_t vecs[33];

    localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001;
    localparam logic [31:0] A2 = 32'hA000_0002, A3 = 32'hA000_0003;
    localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001, B2 = 32'hB000_0002;
    localparam logic [31:0] C0 = 32'hC000_0000;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        int starve_exp;
        starve_exp = 0;

        //      redir rpc                    rdy resp data          ordy  rv addr     ov pc       instr occ
        vecs[0]  = mk(0, 0,                     1, 0, 0,            0,    1, 'h2000, 0, 0,       0,  0);
        vecs[1]  = mk(0, 0,                     0, 1, A0,           0,    0, 0,      0, 0,       0,  0);
        vecs[2]  = mk(0, 0,                     1, 0, 0,            0,    1, 'h2004, 1, 'h2000,  A0, 1);
        vecs[3]  = mk(0, 0,                     0, 1, A1,           0,    0, 0,      1, 'h2000,  A0, 1);
        vecs[4]  = mk(0, 0,                     1, 0, 0,            0,    1, 'h2008, 1, 'h2000,  A0, 2);
        vecs[5]  = mk(0, 0,                     0, 1, A2,           0,    0, 0,      1, 'h2000,  A0, 2);
        vecs[6]  = mk(0, 0,                     1, 0, 0,            0,    1, 'h200C, 1, 'h2000,  A0, 3);
        vecs[7]  = mk(0, 0,                     0, 1, A3,           0,    0, 0,      1, 'h2000,  A0, 3);
        vecs[8]  = mk(0, 0,                     1, 0, 0,            0,    0, 0,      1, 'h2000,  A0, 4);
        vecs[9]  = mk(0, 0,                     1, 0, 0,            0,    0, 0,      1, 'h2000,  A0, 4);
        vecs[10] = mk(0, 0,                     0, 0, 0,            1,    0, 0,      1, 'h2000,  A0, 4);
        vecs[11] = mk(0, 0,                     0, 0, 0,            1,    1, 'h2010, 1, 'h2004,  A1, 3);
        vecs[12] = mk(0, 0,                     0, 0, 0,            1,    1, 'h2010, 1, 'h2008,  A2, 2);
        vecs[13] = mk(0, 0,                     0, 0, 0,            1,    1, 'h2010, 1, 'h200C,  A3, 1);
        vecs[14] = mk(0, 0,                     0, 0, 0,            0,    1, 'h2010, 0, 0,       0,  0);
        vecs[15] = mk(0, 0,                     0, 0, 0,            0,    1, 'h2010, 0, 0,       0,  0);
        vecs[16] = mk(0, 0,                     1, 0, 0,            0,    1, 'h2010, 0, 0,       0,  0);
        vecs[17] = mk(1, 'h3002,                0, 0, 0,            0,    0, 0,      0, 0,       0,  0);
        vecs[18] = mk(0, 0,                     0, 0, 0,            0,    0, 0,      0, 0,       0,  0);
        vecs[19] = mk(0, 0,                     0, 0, 0,            0,    0, 0,      0, 0,       0,  0);
        vecs[20] = mk(0, 0,                     0, 1, 32'hDEAD_BEEF, 0,   0, 0,      0, 0,       0,  0);
        vecs[21] = mk(0, 0,                     1, 0, 0,            0,    1, 'h3000, 0, 0,       0,  0);
        vecs[22] = mk(0, 0,                     0, 1, B0,           0,    0, 0,      0, 0,       0,  0);
        vecs[23] = mk(0, 0,                     1, 0, 0,            0,    1, 'h3004, 1, 'h3000,  B0, 1);
        vecs[24] = mk(0, 0,                     0, 1, B1,           0,    0, 0,      1, 'h3000,  B0, 1);
        vecs[25] = mk(0, 0,                     1, 0, 0,            0,    1, 'h3008, 1, 'h3000,  B0, 2);
        vecs[26] = mk(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, B2,         1,    0, 0,      1, 'h3000,  B0, 2);
        vecs[27] = mk(0, 0,                     1, 0, 0,            0,    1, TOP,    0, 0,       0,  0);
        vecs[28] = mk(0, 0,                     0, 1, C0,           0,    0, 0,      0, 0,       0,  0);
        vecs[29] = mk(0, 0,                     0, 0, 0,            0,    1, 0,      1, TOP,     C0, 1);
        vecs[30] = mk(1, 'h4000,                1, 0, 0,            0,    1, 0,      1, TOP,     C0, 1);
        vecs[31] = mk(0, 0,                     0, 1, 32'hEEEE_EEEE, 0,   0, 0,      0, 0,       0,  0);
        vecs[32] = mk(0, 0,                     0, 0, 0,            0,    1, 'h4000, 0, 0,       0,  0);

        // ---------------- reset values ----------------
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < 33; i++) begin
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].rdy, vecs[i].resp, vecs[i].data, vecs[i].ordy);
            @(negedge clk);
            check($sformatf("t%0d_req_valid", i), imem_req_valid, vecs[i].e_rv);
            if (vecs[i].e_rv) check($sformatf("t%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
            check($sformatf("t%0d_out_valid", i), out_valid, vecs[i].e_ov);
            check($sformatf("t%0d_occupancy", i), occupancy, vecs[i].e_occ);
            if (vecs[i].e_ov) begin
                check($sformatf("t%0d_out_pc", i), out_pc, vecs[i].e_pc);
                check($sformatf("t%0d_out_instr", i), out_instr, vecs[i].e_instr);
            end
            if (vecs[i].ordy && !vecs[i].e_ov) starve_exp++;
            @(posedge clk); #1;
        end
`ifdef TINKER_FETCH_PERF_EN
        check("perf_redirects", perf_redirects, 3);
        check("perf_starve", perf_starve, starve_exp);
`endif

        // ---------------- reset with a request in flight ----------------
        drive(0, 0, 1, 0, 0, 0);              // 0x4000 accepted here
        @(negedge clk);
        check("mid_req_valid", imem_req_valid, 1);
        check("mid_req_addr", imem_req_addr, 64'h4000);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("mid_rst_req_valid", imem_req_valid, 0);
        check("mid_rst_occupancy", occupancy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 0, 0, 1, 32'h1234_5678, 0);  // late response, no request outstanding
        @(negedge clk);
        check("late_req_valid", imem_req_valid, 1);
        check("late_req_addr", imem_req_addr, 64'h2000);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("late_occupancy", occupancy, 0);
        check("late_out_valid", out_valid, 0);
        check("late_req_addr2", imem_req_addr, 64'h2000);
`ifdef TINKER_FETCH_PERF_EN
        check("perf_redirects_rst", perf_redirects, 0);
`endif

        // ---------------- random traffic vs. model ----------------
        mq.delete();
        m_pc          = 64'h2000;
        m_outstanding = 0;
        m_stale       = 0;
        mem_busy      = 0;
        mem_wait      = 0;
        mem_addr      = 0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        r_redir, r_rdy, r_resp, r_ordy, e_rv, acc;
            logic [63:0] r_pc;
            logic [31:0] r_data;
            int          ordy_pct;

            ordy_pct = ((cyc / 250) % 2 == 0) ? 30 : 85;
            r_redir  = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) r_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            else                           r_pc = {$urandom, $urandom};
            r_rdy    = ($urandom_range(0, 3) != 0);
            r_ordy   = ($urandom_range(0, 99) < ordy_pct);
            r_resp   = mem_busy && (mem_wait == 0);
            r_data   = r_resp ? instr_of(mem_addr) : 32'($urandom);
            drive(r_redir, r_pc, r_rdy, r_resp, r_data, r_ordy);

            e_rv = !m_outstanding && (mq.size() < DEPTH);
            @(negedge clk);
            check("rnd_req_valid", imem_req_valid, e_rv);
            if (e_rv) check("rnd_req_addr", imem_req_addr, m_pc);
            check("rnd_out_valid", out_valid, mq.size() != 0);
            check("rnd_occupancy", occupancy, 64'(mq.size()));
            if (mq.size() != 0) begin
                check("rnd_out_pc", out_pc, mq[0].pc);
                check("rnd_out_instr", out_instr, mq[0].instr);
            end

            // Model update for the coming clock edge.
            acc = e_rv && r_rdy;
            if (r_redir) begin
                mq.delete();
                m_pc = {r_pc[63:2], 2'b00};
                if (m_outstanding && r_resp) m_outstanding = 0;
                else if (m_outstanding)      m_stale = 1;
                if (acc) begin
                    m_outstanding = 1;
                    m_stale       = 1;
                end
            end else begin
                if (mq.size() != 0 && r_ordy) void'(mq.pop_front());
                if (m_outstanding && r_resp) begin
                    if (!m_stale) begin
                        mq.push_back('{pc: m_pc, instr: r_data});
                        m_pc = m_pc + 64'd4;
                    end
                    m_outstanding = 0;
                    m_stale       = 0;
                end
                if (acc) begin
                    m_outstanding = 1;
                    m_stale       = 0;
                end
            end

            // Memory environment update.
            if (r_resp) mem_busy = 0;
            else if (mem_busy) mem_wait--;
            if (acc) begin
                mem_busy = 1;
                mem_wait = $urandom_range(0, 3);
                mem_addr = m_pc_at_accept(acc, r_redir, r_pc);
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Address of a request accepted this cycle: the pre-update fetch PC.
    // After a redirect the response is discarded, so its data does not matter.
    logic [63:0] m_pc_prev;
    always @(negedge clk) m_pc_prev <= imem_req_addr;

    function automatic logic [63:0] m_pc_at_accept(input logic acc, input logic redir,
                                                   input logic [63:0] rpc);
        if (!acc) return 64'd0;
        if (redir) return {rpc[63:2], 2'b00};
        return m_pc;
    endfunction

endmodule
